// File: rtl/riscv_serial_div_unit_pkg.sv
// Shared definitions for the serial divider: ALU div/rem operator encodings,
// the divider FSM state type and an operator-decode helper.
package riscv_serial_div_unit_pkg;

  localparam int ALU_OP_WIDTH = 7;

  // bit0 = signed, bit1 = remainder
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIVU = 7'b0110000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_DIV  = 7'b0110001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REMU = 7'b0110010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_REM  = 7'b0110011;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_FIX,
    DIV_DONE
  } div_state_t;

  function automatic logic is_div_op(input logic [ALU_OP_WIDTH-1:0] op);
    return op inside {ALU_DIVU, ALU_DIV, ALU_REMU, ALU_REM};
  endfunction

endpackage

// File: rtl/riscv_serial_div_unit_if.sv
// Request/response bundle between the EX stage (master) and the serial divider (slave).
interface riscv_serial_div_unit_if #(
  parameter int WIDTH = 32,
  parameter int OP_W  = riscv_serial_div_unit_pkg::ALU_OP_WIDTH
);

  logic             enable_i;
  logic [OP_W-1:0]  operator_i;
  logic [WIDTH-1:0] op_a_i;
  logic [WIDTH-1:0] op_b_i;
  logic             flush_i;
  logic             ex_ready_i;
  logic             ready_o;
  logic             valid_o;
  logic [WIDTH-1:0] result_o;

  modport master (
    output enable_i, operator_i, op_a_i, op_b_i, flush_i, ex_ready_i,
    input  ready_o, valid_o, result_o
  );

  modport slave (
    input  enable_i, operator_i, op_a_i, op_b_i, flush_i, ex_ready_i,
    output ready_o, valid_o, result_o
  );

endinterface

// File: rtl/riscv_div_step.sv
// One restoring radix-2 division step: shift {rem,quot} left, subtract the
// divisor when the shifted partial remainder is large enough.
module riscv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quot_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quot_out
);

  // Carry bit of the shifted remainder must take part in the compare.
  logic [WIDTH:0] shifted;
  logic           ge;

  assign shifted  = {rem_in, quot_in[WIDTH-1]};
  assign ge       = shifted >= {1'b0, divisor};
  // The difference is always below the divisor, so it fits in WIDTH bits.
  assign rem_out  = ge ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
  assign quot_out = {quot_in[WIDTH-2:0], ge};

endmodule

// File: rtl/riscv_serial_div_unit.sv
// Multi-cycle div/rem unit for the EX stage: restoring radix-2 division on
// operand magnitudes, sign fix-up, RISC-V special cases, valid/accept handshake.
module riscv_serial_div_unit
  import riscv_serial_div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OP_W  = ALU_OP_WIDTH
) (
  input logic                   clk,
  input logic                   rst_n,
  riscv_serial_div_unit_if.slave bus
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  div_state_t       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] divisor;
  logic             neg_q;
  logic             neg_r;
  logic             is_rem;
  logic             ready;
  logic             valid;
  logic [WIDTH-1:0] result;

  logic             in_signed;
  logic             in_rem;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic             div_by_zero;
  logic             overflow;
  logic             accept;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quot;
  logic [WIDTH-1:0] fix_q;
  logic [WIDTH-1:0] fix_r;

  assign in_signed   = bus.operator_i[0];
  assign in_rem      = bus.operator_i[1];
  assign abs_a       = (in_signed && bus.op_a_i[WIDTH-1]) ? -bus.op_a_i : bus.op_a_i;
  assign abs_b       = (in_signed && bus.op_b_i[WIDTH-1]) ? -bus.op_b_i : bus.op_b_i;
  assign div_by_zero = (bus.op_b_i == '0);
  assign overflow    = in_signed && (bus.op_a_i == MIN_VAL) && (bus.op_b_i == ALL_ONES);
  assign accept      = bus.enable_i && ready && is_div_op(bus.operator_i);

  riscv_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in   (rem),
    .quot_in  (quot),
    .divisor  (divisor),
    .rem_out  (step_rem),
    .quot_out (step_quot)
  );

  assign fix_q = neg_q ? -quot : quot;
  assign fix_r = neg_r ? -rem  : rem;

  // NOTE: all state updates below use non-blocking assignments so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= DIV_IDLE;
      count   <= '0;
      rem     <= '0;
      quot    <= '0;
      divisor <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      is_rem  <= 1'b0;
      ready   <= 1'b1;
      valid   <= 1'b0;
      result  <= '0;
    end else if (bus.flush_i) begin
      // Flush beats both result hand-off and a same-cycle accept.
      state <= DIV_IDLE;
      ready <= 1'b1;
      valid <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (accept) begin
            ready  <= 1'b0;
            is_rem <= in_rem;
            if (div_by_zero) begin
              result <= in_rem ? bus.op_a_i : ALL_ONES;
              valid  <= 1'b1;
              state  <= DIV_DONE;
            end else if (overflow) begin
              result <= in_rem ? '0 : MIN_VAL;
              valid  <= 1'b1;
              state  <= DIV_DONE;
            end else begin
              rem     <= '0;
              quot    <= abs_a;
              divisor <= abs_b;
              count   <= CNT_W'(WIDTH - 1);
              neg_q   <= in_signed && (bus.op_a_i[WIDTH-1] ^ bus.op_b_i[WIDTH-1]);
              neg_r   <= in_signed && bus.op_a_i[WIDTH-1];
              state   <= DIV_RUN;
            end
          end
        end
        DIV_RUN: begin
          rem  <= step_rem;
          quot <= step_quot;
          if (count == '0) begin
            state <= DIV_FIX;
          end else begin
            count <= count - 1'b1;
          end
        end
        DIV_FIX: begin
          result <= is_rem ? fix_r : fix_q;
          valid  <= 1'b1;
          state  <= DIV_DONE;
        end
        DIV_DONE: begin
          if (bus.ex_ready_i) begin
            valid <= 1'b0;
            ready <= 1'b1;
            state <= DIV_IDLE;
          end
        end
        default: begin
          state <= DIV_IDLE;
          ready <= 1'b1;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_o  = ready;
  assign bus.valid_o  = valid;
  assign bus.result_o = result;

endmodule

// File: tb/tb_riscv_serial_div_unit.sv
// Self-checking bench for riscv_serial_div_unit: vector table plus scoreboard,
// with hand-written flush, stall-in-DONE and async-reset sequences.
module tb_riscv_serial_div_unit;

  localparam int W = 32;
  localparam logic [6:0] OP_DIVU = 7'b0110000;
  localparam logic [6:0] OP_DIV  = 7'b0110001;
  localparam logic [6:0] OP_REMU = 7'b0110010;
  localparam logic [6:0] OP_REM  = 7'b0110011;
  localparam logic [6:0] OP_ADD  = 7'b0011000;
  localparam int LAT_NORM = W + 2;
  localparam int LAT_SPEC = 1;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  exp_t sb[$];
  vec_t vecs[12];

  riscv_serial_div_unit_if #(.WIDTH(W), .OP_W(7)) bus ();

  riscv_serial_div_unit #(.WIDTH(W), .OP_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [6:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic sgn;
    logic rm;
    sgn = op[0];
    rm  = op[1];
    if (b == 32'd0) return rm ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rm ? 32'd0 : 32'h8000_0000;
    if (sgn) return rm ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return rm ? (a % b) : (a / b);
  endfunction

  // Called just after a negedge: present the request across one rising edge.
  task automatic request(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.enable_i   = 1'b1;
    bus.operator_i = op;
    bus.op_a_i     = a;
    bus.op_b_i     = b;
    @(negedge clk);
    bus.enable_i   = 1'b0;
  endtask

  // Called at the first negedge after the accept edge; counts negedges until valid_o.
  task automatic wait_result();
    int   lat;
    exp_t e;
    lat = 1;
    while (!bus.valid_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard: result appeared with no expectation queued");
    end else begin
      e = sb.pop_front();
      check({e.name, "_latency"}, 32'(lat), 32'(e.lat));
      check({e.name, "_result"}, bus.result_o, e.res);
    end
  endtask

  task automatic run_vec(input string name, input logic [6:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    exp_t e;
    check({name, "_ready_before"}, 32'(bus.ready_o), 32'd1);
    e.name = name;
    e.res  = exp_res;
    e.lat  = exp_lat;
    sb.push_back(e);
    request(op, a, b);
    wait_result();
    @(negedge clk);
    check({name, "_valid_after"}, 32'(bus.valid_o), 32'd0);
    check({name, "_ready_after"}, 32'(bus.ready_o), 32'd1);
  endtask

  initial begin
    logic        saw_valid;
    logic        hold_ok;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [6:0]  rop;
    logic [31:0] rexp;
    int          rlat;
    exp_t        e;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.enable_i   = 1'b0;
    bus.operator_i = '0;
    bus.op_a_i     = '0;
    bus.op_b_i     = '0;
    bus.flush_i    = 1'b0;
    bus.ex_ready_i = 1'b1;

    vecs[0]  = '{"divu_100_7",  OP_DIVU, 32'd100,      32'd7,        32'd14,       LAT_NORM};
    vecs[1]  = '{"remu_100_7",  OP_REMU, 32'd100,      32'd7,        32'd2,        LAT_NORM};
    vecs[2]  = '{"div_m20_3",   OP_DIV,  32'hFFFF_FFEC, 32'd3,       32'hFFFF_FFFA, LAT_NORM};
    vecs[3]  = '{"rem_m20_3",   OP_REM,  32'hFFFF_FFEC, 32'd3,       32'hFFFF_FFFE, LAT_NORM};
    vecs[4]  = '{"divu_5_0",    OP_DIVU, 32'd5,        32'd0,        32'hFFFF_FFFF, LAT_SPEC};
    vecs[5]  = '{"rem_5_0",     OP_REM,  32'd5,        32'd0,        32'd5,        LAT_SPEC};
    vecs[6]  = '{"div_min_m1",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SPEC};
    vecs[7]  = '{"rem_min_m1",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,      LAT_SPEC};
    vecs[8]  = '{"divu_min_m1", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,      LAT_NORM};
    vecs[9]  = '{"rem_7_m2",    OP_REM,  32'd7,        32'hFFFF_FFFE, 32'd1,       LAT_NORM};
    vecs[10] = '{"div_m7_2",    OP_DIV,  32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, LAT_NORM};
    vecs[11] = '{"divu_max_1",  OP_DIVU, 32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFFF, LAT_NORM};

    // Reset values, sampled while reset is held.
    @(negedge clk);
    check("reset_ready", 32'(bus.ready_o), 32'd1);
    check("reset_valid", 32'(bus.valid_o), 32'd0);
    check("reset_result", bus.result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i])
      run_vec(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_lat);

    // Random operands against the reference model.
    for (int i = 0; i < 6; i++) begin
      ra   = $urandom;
      rb   = (i == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
      rop  = {5'b01100, 2'($urandom_range(0, 3))};
      rexp = model(rop, ra, rb);
      rlat = (rb == 32'd0 || (rop[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF))
             ? LAT_SPEC : LAT_NORM;
      run_vec($sformatf("rand%0d", i), rop, ra, rb, rexp, rlat);
    end

    // Non-div operator is ignored.
    request(OP_ADD, 32'd1, 32'd2);
    check("bad_op_ready", 32'(bus.ready_o), 32'd1);
    check("bad_op_valid", 32'(bus.valid_o), 32'd0);
    @(negedge clk);

    // Flush during the iteration phase.
    request(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    check("flush_ready", 32'(bus.ready_o), 32'd1);
    check("flush_valid", 32'(bus.valid_o), 32'd0);
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      saw_valid |= bus.valid_o;
    end
    check("flush_no_valid", 32'(saw_valid), 32'd0);
    run_vec("divu_9_3_after_flush", OP_DIVU, 32'd9, 32'd3, 32'd3, LAT_NORM);

    // Stall in DONE with ex_ready_i low; enable_i during DONE must be ignored.
    bus.ex_ready_i = 1'b0;
    e = '{"hold_divu_100_7", 32'd14, LAT_NORM};
    sb.push_back(e);
    request(OP_DIVU, 32'd100, 32'd7);
    wait_result();
    hold_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        bus.enable_i   = 1'b1;
        bus.operator_i = OP_DIVU;
        bus.op_a_i     = 32'd50;
        bus.op_b_i     = 32'd5;
      end
      @(negedge clk);
      if (!(bus.valid_o === 1'b1 && bus.result_o === 32'd14 && bus.ready_o === 1'b0))
        hold_ok = 1'b0;
    end
    check("hold_stable", 32'(hold_ok), 32'd1);
    // Release with enable_i still high: the hand-off edge only returns to IDLE.
    e = '{"divu_50_5_after_done", 32'd10, LAT_NORM};
    sb.push_back(e);
    bus.ex_ready_i = 1'b1;
    @(negedge clk);
    check("done_exit_valid", 32'(bus.valid_o), 32'd0);
    check("done_exit_ready", 32'(bus.ready_o), 32'd1);
    @(negedge clk);
    bus.enable_i = 1'b0;
    wait_result();
    @(negedge clk);

    // Asynchronous reset in the middle of an iteration.
    request(OP_DIVU, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ready", 32'(bus.ready_o), 32'd1);
    check("async_rst_valid", 32'(bus.valid_o), 32'd0);
    check("async_rst_result", bus.result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec("divu_9_3_after_rst", OP_DIVU, 32'd9, 32'd3, 32'd3, LAT_NORM);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
